net_div_sched: RTL and testbench

NET_DIV_SCHED -- requirements
Module: net_div_sched

---
 rtl/net_div_pkg.sv | 21 ++
 rtl/net_rr_arb.sv | 31 +++
 rtl/net_div_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_net_div_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_div_pkg.sv
// net_div_pkg: shared types and constants for the divider scheduler.
//   sched_state_e - scheduler FSM states
//   res_flags_t   - per-slot status flags
//   DBZ_QUOT_BIT  - fill bit replicated to form the divide-by-zero quotient
package net_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic dbz;
        logic tmo;
    } res_flags_t;

    // Divide-by-zero quotient is all ones at whatever width the block uses.
    localparam logic DBZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/net_rr_arb.sv
// net_rr_arb: round-robin arbiter, purely combinational.
//   req        - request vector
//   last_grant - index granted last time; search starts one above it
//   grant      - one-hot grant
//   valid      - any request granted
module net_rr_arb #(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    always_comb begin
        logic [IW-1:0] idx;
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        // Walk the requesters in rotated order; the first hit wins.
        for (int k = 0; k < N_REQ; k++) begin
            idx = IW'((int'(last_grant) + 1 + k) % N_REQ);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/net_div_sched.sv
// net_div_sched: shares one multi-cycle divider among N_REQ requesters.
// Each requester owns one result slot; a requester is only served while its
// slot is empty, so at most one result per requester is ever in flight.
//   clk_i, rst_i          - clock, async active-high reset
//   req_valid_i/ready_o   - per-requester request / one-hot accept strobe
//   req_a_i, req_b_i      - packed dividends / divisors, requester i at [i*DW +: DW]
//   res_valid_o, res_ack_i- per-slot full flag / consume strobe
//   res_quot_o, res_rem_o - per-slot quotient / remainder
//   res_dbz_o, res_tmo_o  - per-slot divide-by-zero / timeout flags
//   div_*                 - divider handshake: start/ready to launch, end to finish
//   busy_o                - FSM not idle
//   err_tmo_o             - sticky: a divider operation ever timed out
module net_div_sched
    import net_div_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 32,
    parameter int TMO   = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_valid_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic [N_REQ*DW-1:0] req_a_i,
    input  logic [N_REQ*DW-1:0] req_b_i,
    output logic [N_REQ-1:0]    res_valid_o,
    input  logic [N_REQ-1:0]    res_ack_i,
    output logic [N_REQ*DW-1:0] res_quot_o,
    output logic [N_REQ*DW-1:0] res_rem_o,
    output logic [N_REQ-1:0]    res_dbz_o,
    output logic [N_REQ-1:0]    res_tmo_o,
    output logic                div_start_o,
    output logic [DW-1:0]       div_a_o,
    output logic [DW-1:0]       div_b_o,
    input  logic                div_ready_i,
    input  logic                div_end_i,
    input  logic [DW-1:0]       div_quot_i,
    input  logic [DW-1:0]       div_rem_i,
    output logic                busy_o,
    output logic                err_tmo_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

    sched_state_e state_q, state_d;

    logic [IW-1:0] last_grant_q;
    logic [IW-1:0] id_q;
    logic [DW-1:0] a_q, b_q;
    logic [CW-1:0] cnt_q;
    logic          err_tmo_q;

    // Result slots
    logic       [N_REQ-1:0]         slot_vld;
    logic       [N_REQ-1:0][DW-1:0] slot_quot;
    logic       [N_REQ-1:0][DW-1:0] slot_rem;
    res_flags_t [N_REQ-1:0]         slot_flags;

    // Arbitration
    logic [N_REQ-1:0] arb_req, arb_gnt;
    logic             arb_vld;
    logic [IW-1:0]    gnt_id;
    logic [DW-1:0]    gnt_a, gnt_b;

    // FSM-generated controls
    logic          take_grant;
    logic          cnt_clr, cnt_inc, set_tmo;
    logic          wr_en;
    logic [IW-1:0] wr_id;
    logic [DW-1:0] wr_quot, wr_rem;
    res_flags_t    wr_flags;

    // Requests are only considered in IDLE and never while reset is held,
    // which keeps req_ready_o low during reset even with requests pending.
    assign arb_req = (state_q == IDLE && !rst_i) ? (req_valid_i & ~slot_vld) : '0;

    net_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .grant      (arb_gnt),
        .valid      (arb_vld)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) gnt_id = IW'(i);
        end
    end

    assign gnt_a = req_a_i[int'(gnt_id)*DW +: DW];
    assign gnt_b = req_b_i[int'(gnt_id)*DW +: DW];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        div_start_o = 1'b0;
        take_grant  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        set_tmo     = 1'b0;
        wr_en       = 1'b0;
        wr_id       = id_q;
        wr_quot     = '0;
        wr_rem      = '0;
        wr_flags    = '0;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    take_grant = 1'b1;
                    if (gnt_b == '0) begin
                        // Divide by zero is answered locally; divider stays idle.
                        wr_en        = 1'b1;
                        wr_id        = gnt_id;
                        wr_quot      = {DW{DBZ_QUOT_BIT}};
                        wr_rem       = gnt_a;
                        wr_flags.dbz = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                div_start_o = div_ready_i;
                if (div_ready_i) begin
                    state_d = WAIT;
                    cnt_clr = 1'b1;
                end
            end
            WAIT: begin
                if (div_end_i) begin
                    wr_en   = 1'b1;
                    wr_quot = div_quot_i;
                    wr_rem  = div_rem_i;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    wr_en        = 1'b1;
                    wr_flags.tmo = 1'b1;
                    set_tmo      = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operation registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= IW'(N_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            err_tmo_q    <= 1'b0;
        end else begin
            if (take_grant) begin
                last_grant_q <= gnt_id;
                id_q         <= gnt_id;
                a_q          <= gnt_a;
                b_q          <= gnt_b;
            end
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + CW'(1);
            if (set_tmo) err_tmo_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result slots. A write only ever targets an empty slot (eligibility
    // requires it), so write and ack never collide on the same slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_vld   <= '0;
            slot_quot  <= '0;
            slot_rem   <= '0;
            slot_flags <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (wr_en && wr_id == IW'(i)) begin
                    slot_vld[i]   <= 1'b1;
                    slot_quot[i]  <= wr_quot;
                    slot_rem[i]   <= wr_rem;
                    slot_flags[i] <= wr_flags;
                end else if (res_ack_i[i] && slot_vld[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        res_dbz_o = '0;
        res_tmo_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            res_dbz_o[i] = slot_flags[i].dbz;
            res_tmo_o[i] = slot_flags[i].tmo;
        end
    end

    assign req_ready_o = arb_gnt;
    assign res_valid_o = slot_vld;
    assign res_quot_o  = slot_quot;
    assign res_rem_o   = slot_rem;
    assign div_a_o     = a_q;
    assign div_b_o     = b_q;
    assign busy_o      = (state_q != IDLE);
    assign err_tmo_o   = err_tmo_q;

endmodule

// File: tb/tb_net_div_sched.sv
// tb_net_div_sched: directed scenarios with a result scoreboard and a
// fixed-latency divider model.
module tb_net_div_sched;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int TMO = 64;
    localparam int LAT = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N-1:0]    res_valid;
    logic [N-1:0]    res_ack = '0;
    logic [N*DW-1:0] res_quot, res_rem;
    logic [N-1:0]    res_dbz, res_tmo;
    logic            div_start, div_ready;
    logic [DW-1:0]   div_a, div_b;
    logic            div_end = 1'b0;
    logic [DW-1:0]   div_quot = '0;
    logic [DW-1:0]   div_rem = '0;
    logic            busy, err_tmo;

    net_div_sched #(.N_REQ(N), .DW(DW), .TMO(TMO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .res_valid_o (res_valid),
        .res_ack_i   (res_ack),
        .res_quot_o  (res_quot),
        .res_rem_o   (res_rem),
        .res_dbz_o   (res_dbz),
        .res_tmo_o   (res_tmo),
        .div_start_o (div_start),
        .div_a_o     (div_a),
        .div_b_o     (div_b),
        .div_ready_i (div_ready),
        .div_end_i   (div_end),
        .div_quot_i  (div_quot),
        .div_rem_i   (div_rem),
        .busy_o      (busy),
        .err_tmo_o   (err_tmo)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- divider model ----------------
    logic          m_busy = 1'b0;
    logic          m_hang = 1'b0;
    int            m_cnt  = 0;
    logic [DW-1:0] m_a = '0, m_b = '0;
    assign div_ready = !m_busy;

    always @(posedge clk) begin
        div_end <= 1'b0;
        if (div_start && div_ready) begin
            if (!m_hang) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_a    <= div_a;
                m_b    <= div_b;
            end
        end else if (m_busy) begin
            if (m_cnt == LAT - 1) begin
                div_end  <= 1'b1;
                div_quot <= m_a / m_b;
                div_rem  <= m_a % m_b;
                m_busy   <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard / monitors ----------------
    typedef struct packed {
        logic [7:0]    id;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
        logic          tmo;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       gnt_ids[$];
    int       gnt_cyc[$];
    int       gcount[N] = '{default: 0};
    int       want[N]   = '{default: 0};
    int       rise_cyc[N] = '{default: 0};
    int       n_start   = 0;
    int       start_cyc = 0;
    logic [N-1:0] rv_prev = '0;
    logic [N-1:0] auto_ack = '0;

    always @(negedge clk) begin
        exp_t e;
        if (req_ready != '0) begin
            check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    gnt_ids.push_back(i);
                    gnt_cyc.push_back(cyc);
                    gcount[i]++;
                end
            end
        end
        if (div_start) begin
            n_start++;
            start_cyc = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (res_valid[i] && !rv_prev[i]) begin
                rise_cyc[i] = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_result_slot", 64'(i), 64'hFF);
                end else begin
                    e = sb.pop_front();
                    check("res_id",   64'(i), 64'(e.id));
                    check("res_quot", 64'(res_quot[i*DW +: DW]), 64'(e.q));
                    check("res_rem",  64'(res_rem[i*DW +: DW]),  64'(e.r));
                    check("res_dbz",  64'(res_dbz[i]), 64'(e.dbz));
                    check("res_tmo",  64'(res_tmo[i]), 64'(e.tmo));
                end
            end
        end
        rv_prev = res_valid;
    end

    // Requesters hold valid until their wanted number of grants is reached.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) req_valid[i] = (gcount[i] < want[i]);
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) res_ack[i] = auto_ack[i] & res_valid[i];
    end

    // ---------------- helpers ----------------
    task automatic set_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
    endtask

    task automatic push_div(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.id = 8'(id);
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.tmo = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.tmo = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic push_tmo(input int id);
        exp_t e;
        e.id = 8'(id); e.q = '0; e.r = '0; e.dbz = 1'b0; e.tmo = 1'b1;
        sb.push_back(e);
    endtask

    task automatic request(input int id, input int n);
        want[id] = gcount[id] + n;
    endtask

    function automatic logic served();
        for (int i = 0; i < N; i++) if (gcount[i] < want[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Wait until at most `left` results are outstanding and the FSM is idle.
    task automatic wait_sb(input string tag, input int left, input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(sb.size() <= left && !busy && (left != 0 || served())) && n < budget);
        check(tag, 64'(n < budget), 64'd1);
    endtask

    function automatic int gid(input int k);
        return (k < gnt_ids.size()) ? gnt_ids[k] : -1;
    endfunction

    function automatic int gc(input int k);
        return (k < gnt_cyc.size()) ? gnt_cyc[k] : -1000;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s0, g0, ack_cyc;
        int order[5];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_err_tmo",   64'(err_tmo), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_res_quot",  64'(|res_quot), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Plain division on requester 1, left unacked.
        s0 = n_start;
        set_op(1, 32'd100, 32'd7);
        push_div(1, 32'd100, 32'd7);
        request(1, 1);
        wait_sb("t1_done", 0, 300);
        check("t1_start_pulses", 64'(n_start - s0), 64'd1);
        check("t1_valid_held",   64'(res_valid[1]), 64'd1);

        // Divide by zero on requester 2: local answer, no divider traffic.
        s0 = n_start;
        g0 = gnt_ids.size();
        set_op(2, 32'h55, 32'd0);
        push_div(2, 32'h55, 32'd0);
        request(2, 1);
        wait_sb("t2_done", 0, 50);
        check("t2_start_pulses", 64'(n_start - s0), 64'd0);
        check("t2_latency",      64'(rise_cyc[2] - gc(g0)), 64'd1);
        check("t1_slot_held",    64'(res_quot[1*DW +: DW]), 64'd14);

        // All four requesting with immediate acks: round-robin order.
        do_reset();
        auto_ack = 4'b1111;
        set_op(0, 32'd1000, 32'd10);
        set_op(1, 32'd77, 32'd5);
        set_op(2, 32'hFFFF_FFFF, 32'd16);
        set_op(3, 32'd12345, 32'd1000);
        push_div(0, 32'd1000, 32'd10);
        push_div(1, 32'd77, 32'd5);
        push_div(2, 32'hFFFF_FFFF, 32'd16);
        push_div(3, 32'd12345, 32'd1000);
        push_div(0, 32'd1000, 32'd10);
        g0 = gnt_ids.size();
        request(0, 2); request(1, 1); request(2, 1); request(3, 1);
        wait_sb("t3_done", 0, 800);
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) check($sformatf("t3_order_%0d", k), 64'(gid(g0 + k)), 64'(order[k]));
        check("t3_err_tmo", 64'(err_tmo), 64'd0);

        // Requester 0 unacked blocks only itself; regranted right after ack.
        do_reset();
        auto_ack = 4'b1000;
        set_op(0, 32'd100, 32'd7);
        set_op(3, 32'd1000, 32'd3);
        push_div(0, 32'd100, 32'd7);
        push_div(3, 32'd1000, 32'd3);
        push_div(0, 32'd100, 32'd7);
        g0 = gnt_ids.size();
        request(0, 2); request(3, 1);
        wait_sb("t4_first_two", 1, 300);
        repeat (10) @(negedge clk);
        #1;
        check("t4_no_regrant", 64'(gnt_ids.size() - g0), 64'd2);
        check("t4_first",      64'(gid(g0)), 64'd0);
        check("t4_second",     64'(gid(g0 + 1)), 64'd3);
        check("t4_slot0_full", 64'(res_valid[0]), 64'd1);
        @(posedge clk); #1;
        auto_ack[0] = 1'b1;
        ack_cyc = cyc;
        wait_sb("t4_done", 0, 300);
        check("t4_regrant_id",  64'(gid(g0 + 2)), 64'd0);
        check("t4_regrant_cyc", 64'(gc(g0 + 2) - ack_cyc), 64'd1);

        // Divider never answers: timeout after TMO wait cycles, sticky error.
        do_reset();
        auto_ack = 4'b0010;
        m_hang = 1'b1;
        set_op(0, 32'd50, 32'd5);
        push_tmo(0);
        request(0, 1);
        wait_sb("t5_tmo_done", 0, 300);
        check("t5_tmo_latency", 64'(rise_cyc[0] - start_cyc), 64'(TMO + 1));
        check("t5_err_tmo",     64'(err_tmo), 64'd1);
        m_hang = 1'b0;
        set_op(1, 32'd100, 32'd7);
        push_div(1, 32'd100, 32'd7);
        request(1, 1);
        wait_sb("t5_next_done", 0, 300);
        check("t5_err_sticky", 64'(err_tmo), 64'd1);
        check("t5_slot0_tmo",  64'(res_tmo[0]), 64'd1);
        check("t5_slot0_vld",  64'(res_valid[0]), 64'd1);

        // Reset mid-WAIT: late div_end must not create a result.
        auto_ack = 4'b1111;
        set_op(2, 32'd9, 32'd2);
        s0 = n_start;
        request(2, 1);
        begin
            int n = 0;
            do begin @(negedge clk); #1; n++; end while (n_start == s0 && n < 50);
            check("t6_started", 64'(n < 50), 64'd1);
        end
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("t6_rst_valid", 64'(res_valid), 64'd0);
        check("t6_rst_busy",  64'(busy), 64'd0);
        check("t6_rst_err",   64'(err_tmo), 64'd0);
        check("t6_rst_tmo",   64'(res_tmo), 64'd0);
        repeat (50) @(negedge clk);
        #1;
        check("t6_late_valid", 64'(res_valid), 64'd0);
        check("t6_late_busy",  64'(busy), 64'd0);
        check("t6_late_quot",  64'(|res_quot), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
